// File: rtl/adder64_brent_kung_pkg.sv
// Shared constants, the generate/propagate pair type and the Brent-Kung prefix operator
// used by the 64-bit adder and its prefix tree.
package adder64_brent_kung_pkg;

    localparam int WIDTH = 64;
    localparam int LOGW  = $clog2(WIDTH);

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // (G,P)hi o (G,P)lo: hi is the more significant span, lo sits directly below it.
    function automatic pg_t pgCombine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/adder64_brent_kung_bk_prefix_tree.sv
// Combinational Brent-Kung parallel-prefix network: per-bit generate/propagate in,
// group generate G[i:0] for every bit position out.
module bk_prefix_tree
    import adder64_brent_kung_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] iG,
    input  logic [W-1:0] iP,
    output logic [W-1:0] oG
);

    localparam int LW     = $clog2(W);
    localparam int STAGES = 2 * LW;

    // Stage 0 is the raw bit level; stages 1..LW are the up-sweep, the rest the down-sweep.
    // Group propagate is only carried into stages that still have a consumer.
    for (genvar s = 0; s < STAGES; s++) begin : gStage
        localparam bit UP   = (s <= LW);
        localparam int LVL  = UP ? s : (2 * LW - s);
        localparam int SPAN = 1 << LVL;
        localparam int HALF = SPAN / 2;

        logic [W-1:0] g;

        if (s == 0) begin : gInit
            assign g = iG;
        end else begin : gLevel
            always_comb begin
                pg_t hi;
                pg_t lo;
                pg_t r;
                hi = '0;
                lo = '0;
                r  = '0;
                g  = gStage[s-1].g;
                for (int i = 0; i < W; i++) begin
                    if (UP ? ((i + 1) % SPAN == 0)
                           : (((i + 1) % SPAN == HALF) && (i >= SPAN))) begin
                        hi   = '{g: gStage[s-1].g[i],      p: gStage[s-1].gProp.p[i]};
                        lo   = '{g: gStage[s-1].g[i-HALF], p: gStage[s-1].gProp.p[i-HALF]};
                        r    = pgCombine(hi, lo);
                        g[i] = r.g;
                    end
                end
            end
        end

        if (s < STAGES - 1) begin : gProp
            logic [W-1:0] p;
            if (s == 0) begin : gInitP
                assign p = iP;
            end else begin : gLevelP
                always_comb begin
                    pg_t hi;
                    pg_t lo;
                    pg_t r;
                    hi = '0;
                    lo = '0;
                    r  = '0;
                    p  = gStage[s-1].gProp.p;
                    for (int i = 0; i < W; i++) begin
                        if (UP ? ((i + 1) % SPAN == 0)
                               : (((i + 1) % SPAN == HALF) && (i >= SPAN))) begin
                            hi   = '{g: gStage[s-1].g[i],      p: gStage[s-1].gProp.p[i]};
                            lo   = '{g: gStage[s-1].g[i-HALF], p: gStage[s-1].gProp.p[i-HALF]};
                            r    = pgCombine(hi, lo);
                            p[i] = r.p;
                        end
                    end
                end
            end
        end
    end

    assign oG = gStage[STAGES-1].g;

endmodule

// File: rtl/adder64_brent_kung.sv
// 64-bit adder with carry-in on a Brent-Kung prefix tree; one-cycle registered result
// qualified by a single-cycle oReady strobe.
module adder64_brent_kung
    import adder64_brent_kung_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             iValid,
    input  logic [WIDTH-1:0] iX,
    input  logic [WIDTH-1:0] iY,
    input  logic             iCarryIn,
    output logic [WIDTH-1:0] oZ,
    output logic             oCarryOut,
    output logic             oReady
);

    logic [WIDTH-1:0] bitP;
    logic [WIDTH-1:0] bitG;
    logic [WIDTH-1:0] bitGc;
    logic [WIDTH-1:0] groupG;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;

    assign bitP = iX ^ iY;
    assign bitG = iX & iY;

    // Folding Cin into bit 0 makes every group generate G[i:0] the true carry into bit i+1.
    assign bitGc = {bitG[WIDTH-1:1], bitG[0] | (bitP[0] & iCarryIn)};

    bk_prefix_tree #(
        .W (WIDTH)
    ) uTree (
        .iG (bitGc),
        .iP (bitP),
        .oG (groupG)
    );

    assign carry = {groupG[WIDTH-2:0], iCarryIn};
    assign sum   = bitP ^ carry;

    // iValid/oReady: operands are taken whenever iValid is high at an edge; oReady is a
    // one-cycle strobe with no backpressure, and oZ/oCarryOut hold between strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            oZ        <= '0;
            oCarryOut <= 1'b0;
            oReady    <= 1'b0;
        end else begin
            oReady <= iValid;
            if (iValid) begin
                oZ        <= sum;
                oCarryOut <= groupG[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_adder64_brent_kung.sv
// Directed and randomized self-checking bench for adder64_brent_kung against a plain
// arithmetic model of {Cout,Z} = X + Y + Cin.
module tb_adder64_brent_kung;

    logic        clk;
    logic        resetn;
    logic        iValid;
    logic [63:0] iX;
    logic [63:0] iY;
    logic        iCarryIn;
    logic [63:0] oZ;
    logic        oCarryOut;
    logic        oReady;

    int checks   = 0;
    int failures = 0;

    logic [64:0] expQ[$];
    logic [64:0] lastExp;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    adder64_brent_kung dut (
        .clk       (clk),
        .resetn    (resetn),
        .iValid    (iValid),
        .iX        (iX),
        .iY        (iY),
        .iCarryIn  (iCarryIn),
        .oZ        (oZ),
        .oCarryOut (oCarryOut),
        .oReady    (oReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [64:0] refAdd(input logic [63:0] x, input logic [63:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {64'd0, c};
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] randOperand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = ONES;
            1: v = '0;
            2: v = ONES >> $urandom_range(0, 63);
            default: ;
        endcase
        return v;
    endfunction

    // One clock: drive on the falling edge, check just after the following rising edge.
    task automatic step(input logic v, input logic [63:0] x, input logic [63:0] y,
                        input logic c);
        logic [64:0] e;
        @(negedge clk);
        iValid   = v;
        iX       = x;
        iY       = y;
        iCarryIn = c;
        if (v) expQ.push_back(refAdd(x, y, c));
        @(posedge clk);
        #1;
        check("ready", {64'd0, oReady}, {64'd0, v});
        if (v) begin
            e = expQ.pop_front();
            lastExp = e;
            check("sum", {oCarryOut, oZ}, e);
        end else begin
            check("hold", {oCarryOut, oZ}, lastExp);
        end
    endtask

    initial begin
        resetn   = 1'b0;
        iValid   = 1'b0;
        iX       = '0;
        iY       = '0;
        iCarryIn = 1'b0;
        lastExp  = '0;

        // Reset held 20 ns with the clock running.
        for (int t = 0; t < 5; t++) begin
            #4;
            check("reset_z", {oCarryOut, oZ}, 65'd0);
            check("reset_ready", {64'd0, oReady}, 65'd0);
        end
        @(negedge clk);
        resetn = 1'b1;

        // Basic add, back-to-back with X = Y = 0xFF, then idle.
        step(1'b1, 64'hFFFF_FFF1, 64'hFF00_110C, 1'b0);
        check("basic", {oCarryOut, oZ}, 65'h1_FF00_10FD);
        step(1'b1, 64'hFF, 64'hFF, 1'b0);
        check("b2b", {oCarryOut, oZ}, 65'h1FE);
        step(1'b0, '0, '0, 1'b0);
        check("b2b_hold", {oCarryOut, oZ}, 65'h1FE);

        // Full wrap, carry-in through a ones chain, and max sum.
        step(1'b1, ONES, 64'd0, 1'b1);
        check("wrap", {oCarryOut, oZ}, {1'b1, 64'd0});
        step(1'b1, ONES, ONES, 1'b1);
        check("max", {oCarryOut, oZ}, {1'b1, ONES});
        step(1'b1, 64'd0, 64'd0, 1'b1);
        check("cin_only", {oCarryOut, oZ}, 65'd1);

        // Randomized operands with random iValid gaps.
        for (int n = 0; n < 10000; n++) begin
            step(($urandom_range(0, 3) != 0), randOperand(), randOperand(),
                 1'($urandom_range(0, 1)));
        end

        // Reset mid-stream with an operand in flight: outputs clear without a clock edge.
        step(1'b1, randOperand(), randOperand(), 1'b1);
        @(negedge clk);
        iValid   = 1'b1;
        iX       = randOperand();
        iY       = randOperand();
        iCarryIn = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_z", {oCarryOut, oZ}, 65'd0);
        check("async_rst_ready", {64'd0, oReady}, 65'd0);
        @(negedge clk);
        check("rst_hold_z", {oCarryOut, oZ}, 65'd0);
        check("rst_hold_ready", {64'd0, oReady}, 65'd0);
        iValid = 1'b0;
        resetn = 1'b1;
        lastExp = '0;
        expQ.delete();
        step(1'b0, '0, '0, 1'b0);
        step(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        check("cold_start", {oCarryOut, oZ}, 65'h0_2222_2222_2222_2211);
        for (int n = 0; n < 50; n++) begin
            step(($urandom_range(0, 1) != 0), randOperand(), randOperand(),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
